// File: rtl/wb_arbiter_pkg.sv
// Shared constants, the default writeback entry layout and a small
// modular-index helper for the writeback arbiter.
package wb_arbiter_pkg;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_PHY_WIDTH  = 6;
    localparam int DEF_ROB_WIDTH  = 5;
    localparam int DEF_NUM_SRC    = 4;
    localparam int DEF_NUM_CDB    = 2;
    localparam int DEF_BUF_DEPTH  = 2;

    typedef struct packed {
        logic [DEF_ROB_WIDTH-1:0]  rob_id;
        logic [DEF_PHY_WIDTH-1:0]  rd_phy;
        logic                      has_rd;
        logic [DEF_DATA_WIDTH-1:0] data;
    } wb_entry_t;

    function automatic int wrap_add(input int a, input int b, input int m);
        return (a + b) % m;
    endfunction

endpackage

// File: rtl/wb_arbiter_src_fifo.sv
// Per-producer skid FIFO: circular storage with natural-wrap pointers and a
// separate occupancy count so full/empty never depend on pointer compare.
module wb_src_fifo #(
    parameter int WIDTH = 44,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;

    assign full  = (count == FULL_CNT);
    assign empty = (count == '0);
    assign head  = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: per-source skid FIFOs drained round-robin onto up to
// NUM_CDB result ports per cycle, with flush and a contention counter.
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int PHY_WIDTH  = DEF_PHY_WIDTH,
    parameter int ROB_WIDTH  = DEF_ROB_WIDTH,
    parameter int NUM_SRC    = DEF_NUM_SRC,
    parameter int NUM_CDB    = DEF_NUM_CDB,
    parameter int BUF_DEPTH  = DEF_BUF_DEPTH
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            flush,
    input  logic [NUM_SRC-1:0]              src_valid,
    output logic [NUM_SRC-1:0]              src_ready,
    input  logic [NUM_SRC*ROB_WIDTH-1:0]    src_rob_id,
    input  logic [NUM_SRC*PHY_WIDTH-1:0]    src_rd_phy,
    input  logic [NUM_SRC-1:0]              src_has_rd,
    input  logic [NUM_SRC*DATA_WIDTH-1:0]   src_data,
    output logic [NUM_CDB-1:0]              cdb_valid,
    output logic [NUM_CDB*ROB_WIDTH-1:0]    cdb_rob_id,
    output logic [NUM_CDB*PHY_WIDTH-1:0]    cdb_rd_phy,
    output logic [NUM_CDB-1:0]              cdb_has_rd,
    output logic [NUM_CDB*DATA_WIDTH-1:0]   cdb_data,
    output logic [NUM_CDB*$clog2(NUM_SRC)-1:0] cdb_src,
    output logic [15:0]                     conflict_cnt
);
    localparam int SW = $clog2(NUM_SRC);

    typedef struct packed {
        logic [ROB_WIDTH-1:0]  rob_id;
        logic [PHY_WIDTH-1:0]  rd_phy;
        logic                  has_rd;
        logic [DATA_WIDTH-1:0] data;
    } entry_t;
    localparam int EW = $bits(entry_t);

    entry_t [NUM_SRC-1:0]        din;
    entry_t [NUM_SRC-1:0]        head;
    logic   [NUM_SRC-1:0]        full;
    logic   [NUM_SRC-1:0]        empty;
    logic   [NUM_SRC-1:0]        push;
    logic   [NUM_SRC-1:0]        pop;
    logic   [SW-1:0]             rr_ptr;
    logic   [SW-1:0]             rr_next;
    logic   [NUM_CDB-1:0]        gnt_vld;
    logic   [NUM_CDB-1:0][SW-1:0] gnt_idx;
    logic                        conflict;

    // Ready looks only at registered occupancy, so a same-cycle pop never
    // opens a slot for the producer.
    assign src_ready = ~full;
    assign push      = src_valid & ~full & {NUM_SRC{~flush}};

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        assign din[i] = '{rob_id: src_rob_id[i*ROB_WIDTH +: ROB_WIDTH],
                          rd_phy: src_rd_phy[i*PHY_WIDTH +: PHY_WIDTH],
                          has_rd: src_has_rd[i],
                          data:   src_data[i*DATA_WIDTH +: DATA_WIDTH]};

        wb_src_fifo #(
            .WIDTH (EW),
            .DEPTH (BUF_DEPTH)
        ) u_fifo (
            .clk   (clk),
            .rst   (rst),
            .flush (flush),
            .push  (push[i]),
            .pop   (pop[i]),
            .din   (din[i]),
            .head  (head[i]),
            .full  (full[i]),
            .empty (empty[i])
        );
    end

    // Scan from rr_ptr; the k-th non-empty source found lands on port k.
    always_comb begin
        int n;
        int idx;
        int last;
        int busy;
        gnt_vld = '0;
        gnt_idx = '0;
        pop     = '0;
        n       = 0;
        idx     = 0;
        last    = int'(rr_ptr);
        busy    = 0;
        for (int j = 0; j < NUM_SRC; j++) begin
            idx = wrap_add(int'(rr_ptr), j, NUM_SRC);
            if (!empty[idx]) begin
                busy = busy + 1;
                if (n < NUM_CDB) begin
                    gnt_vld[n] = 1'b1;
                    gnt_idx[n] = SW'(idx);
                    pop[idx]   = ~flush;
                    last       = idx;
                    n          = n + 1;
                end
            end
        end
        rr_next  = SW'(wrap_add(last, 1, NUM_SRC));
        conflict = (busy > NUM_CDB) && !flush;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr       <= '0;
            conflict_cnt <= '0;
        end else begin
            if (!flush && |gnt_vld) rr_ptr <= rr_next;
            if (conflict && conflict_cnt != 16'hFFFF) conflict_cnt <= conflict_cnt + 16'd1;
        end
    end

    for (genvar k = 0; k < NUM_CDB; k++) begin : g_cdb
        entry_t sel;
        assign cdb_valid[k] = gnt_vld[k] & ~flush;
        assign sel          = cdb_valid[k] ? head[gnt_idx[k]] : '0;
        assign cdb_rob_id[k*ROB_WIDTH +: ROB_WIDTH]   = sel.rob_id;
        assign cdb_rd_phy[k*PHY_WIDTH +: PHY_WIDTH]   = sel.rd_phy;
        assign cdb_has_rd[k]                          = sel.has_rd;
        assign cdb_data[k*DATA_WIDTH +: DATA_WIDTH]   = sel.data;
        assign cdb_src[k*SW +: SW] = cdb_valid[k] ? gnt_idx[k] : '0;
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: a 2-port instance with a per-source
// scoreboard plus a 1-port instance for round-robin rotation.
module tb_wb_arbiter;
    logic         clk;
    logic         rst;
    logic         flush;
    logic [3:0]   src_valid;
    logic [19:0]  src_rob_id;
    logic [23:0]  src_rd_phy;
    logic [3:0]   src_has_rd;
    logic [127:0] src_data;

    logic [3:0]   src_ready;
    logic [1:0]   cdb_valid;
    logic [9:0]   cdb_rob_id;
    logic [11:0]  cdb_rd_phy;
    logic [1:0]   cdb_has_rd;
    logic [63:0]  cdb_data;
    logic [3:0]   cdb_src;
    logic [15:0]  conflict_cnt;

    logic [3:0]   d1_src_ready;
    logic [0:0]   d1_cdb_valid;
    logic [4:0]   d1_cdb_rob_id;
    logic [5:0]   d1_cdb_rd_phy;
    logic [0:0]   d1_cdb_has_rd;
    logic [31:0]  d1_cdb_data;
    logic [1:0]   d1_cdb_src;
    logic [15:0]  d1_conflict_cnt;

    int checks = 0;
    int errors = 0;
    int rd_i[4];
    int wr_i[4];
    logic [36:0] exp_q [4][64];
    logic [15:0] cc_save;

    wb_arbiter u_dut (
        .clk(clk), .rst(rst), .flush(flush),
        .src_valid(src_valid), .src_ready(src_ready),
        .src_rob_id(src_rob_id), .src_rd_phy(src_rd_phy),
        .src_has_rd(src_has_rd), .src_data(src_data),
        .cdb_valid(cdb_valid), .cdb_rob_id(cdb_rob_id), .cdb_rd_phy(cdb_rd_phy),
        .cdb_has_rd(cdb_has_rd), .cdb_data(cdb_data), .cdb_src(cdb_src),
        .conflict_cnt(conflict_cnt)
    );

    wb_arbiter #(.NUM_CDB(1)) u_dut1 (
        .clk(clk), .rst(rst), .flush(flush),
        .src_valid(src_valid), .src_ready(d1_src_ready),
        .src_rob_id(src_rob_id), .src_rd_phy(src_rd_phy),
        .src_has_rd(src_has_rd), .src_data(src_data),
        .cdb_valid(d1_cdb_valid), .cdb_rob_id(d1_cdb_rob_id), .cdb_rd_phy(d1_cdb_rd_phy),
        .cdb_has_rd(d1_cdb_has_rd), .cdb_data(d1_cdb_data), .cdb_src(d1_cdb_src),
        .conflict_cnt(d1_conflict_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; flush = 1'b0; src_valid = '0;
        src_rob_id = '0; src_rd_phy = '0; src_has_rd = 4'hF; src_data = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin rd_i[i] = 0; wr_i[i] = 0; end
    endtask

    // Drive source i with fields derived from its own accept count.
    task automatic drive(input int i, input bit en);
        src_valid[i]          = en;
        src_rob_id[i*5 +: 5]  = 5'(i*8 + wr_i[i] % 8);
        src_rd_phy[i*6 +: 6]  = 6'(i*16 + wr_i[i] % 16);
        src_data[i*32 +: 32]  = 32'(i*65536 + wr_i[i]);
    endtask

    // One clock: check ports against the scoreboard, record accepts, advance.
    task automatic cyc();
        int s;
        #2;
        for (int k = 0; k < 2; k++) begin
            if (cdb_valid[k]) begin
                s = int'(cdb_src[k*2 +: 2]);
                checks++;
                assert (rd_i[s] != wr_i[s]) else begin
                    errors++;
                    $error("FAIL sb_extra observed=port%0d_src%0d expected=no_entry", k, s);
                end
                if (rd_i[s] != wr_i[s]) begin
                    chk("sb_entry", 64'({cdb_rob_id[k*5 +: 5], cdb_data[k*32 +: 32]}),
                        64'(exp_q[s][rd_i[s] % 64]));
                    rd_i[s]++;
                end
            end
        end
        if (!flush) begin
            for (int i = 0; i < 4; i++) begin
                if (src_valid[i] && src_ready[i]) begin
                    exp_q[i][wr_i[i] % 64] = {src_rob_id[i*5 +: 5], src_data[i*32 +: 32]};
                    wr_i[i]++;
                end
            end
        end
        @(posedge clk);
        #1;
        if (flush) for (int i = 0; i < 4; i++) rd_i[i] = wr_i[i];
    endtask

    initial begin
        do_reset();
        chk("rst_valid", 64'(cdb_valid), 64'(0));
        chk("rst_ready", 64'(src_ready), 64'hF);
        chk("rst_conflict", 64'(conflict_cnt), 64'(0));
        chk("rst_data", 64'(cdb_data), 64'(0));
        chk("rst_src", 64'(cdb_src), 64'(0));
        chk("rst_d1_valid", 64'(d1_cdb_valid), 64'(0));

        // Single source on channel 2
        src_valid = 4'b0100;
        src_rob_id[10 +: 5] = 5'd5;
        src_rd_phy[12 +: 6] = 6'd12;
        src_data[64 +: 32]  = 32'hDEAD;
        cyc();
        src_valid = '0;
        chk("single_valid", 64'(cdb_valid), 64'b01);
        chk("single_rob", 64'(cdb_rob_id[4:0]), 64'd5);
        chk("single_rd", 64'(cdb_rd_phy[5:0]), 64'd12);
        chk("single_has_rd", 64'(cdb_has_rd[0]), 64'd1);
        chk("single_data", 64'(cdb_data[31:0]), 64'hDEAD);
        chk("single_src", 64'(cdb_src[1:0]), 64'd2);
        cyc();
        chk("single_idle", 64'(cdb_valid), 64'(0));

        // Contention: four sources at once, two ports
        do_reset();
        src_valid  = 4'hF;
        src_rob_id = {5'd4, 5'd3, 5'd2, 5'd1};
        cyc();
        src_valid = '0;
        chk("cont1_valid", 64'(cdb_valid), 64'b11);
        chk("cont1_src", 64'(cdb_src), 64'b0100);
        chk("cont1_rob", 64'(cdb_rob_id), 64'({5'd2, 5'd1}));
        chk("cont1_conflict", 64'(conflict_cnt), 64'd0);
        cyc();
        chk("cont2_src", 64'(cdb_src), 64'b1110);
        chk("cont2_rob", 64'(cdb_rob_id), 64'({5'd4, 5'd3}));
        chk("cont2_conflict", 64'(conflict_cnt), 64'd1);
        cyc();
        chk("cont3_valid", 64'(cdb_valid), 64'(0));
        chk("cont3_conflict", 64'(conflict_cnt), 64'd1);

        // Backpressure on source 0 while 1..3 keep the ports busy
        do_reset();
        for (int c = 0; c < 30 && wr_i[0] < 5; c++) begin
            for (int i = 0; i < 4; i++) drive(i, 1'b1);
            if (c == 3) begin
                chk("bp_ready_drop", 64'(src_ready[0]), 64'd0);
                chk("bp_accepts_before_drop", 64'(wr_i[0]), 64'd3);
            end
            cyc();
        end
        chk("bp_accepts", 64'(wr_i[0]), 64'd5);
        src_valid = '0;
        repeat (8) cyc();
        for (int i = 0; i < 4; i++) chk("bp_drained", 64'(rd_i[i]), 64'(wr_i[i]));
        chk("bp_out0", 64'(rd_i[0]), 64'd5);
        chk("bp_idle", 64'(cdb_valid), 64'(0));

        // Flush with three FIFOs holding entries
        for (int i = 0; i < 3; i++) drive(i, 1'b1);
        cyc();
        for (int i = 0; i < 3; i++) drive(i, 1'b1);
        cyc();
        flush = 1'b1;
        cc_save = conflict_cnt;
        #1;
        chk("flush_valid", 64'(cdb_valid), 64'(0));
        chk("flush_d1_valid", 64'(d1_cdb_valid), 64'(0));
        cyc();
        flush = 1'b0;
        src_valid = '0;
        chk("flush_ready", 64'(src_ready), 64'hF);
        chk("flush_after_valid", 64'(cdb_valid), 64'(0));
        chk("flush_conflict_hold", 64'(conflict_cnt), 64'(cc_save));
        repeat (4) cyc();

        // Fairness on the single-port instance
        do_reset();
        for (int c = 0; c < 10; c++) begin
            for (int i = 0; i < 3; i++) drive(i, 1'b1);
            if (c >= 1) begin
                chk("fair_valid", 64'(d1_cdb_valid), 64'd1);
                chk("fair_src", 64'(d1_cdb_src), 64'((c - 1) % 3));
            end
            cyc();
        end
        src_valid = '0;
        repeat (8) cyc();

        // Pointer wrap: ten results streamed through source 3
        do_reset();
        for (int n = 0; n <= 10; n++) begin
            src_valid[3]       = (n < 10);
            src_rob_id[15 +: 5] = 5'(n);
            src_data[96 +: 32]  = 32'h1000 + 32'(n);
            if (n >= 1) begin
                chk("wrap_valid", 64'(cdb_valid[0]), 64'd1);
                chk("wrap_data", 64'(cdb_data[31:0]), 64'h1000 + 64'(n - 1));
                chk("wrap_src", 64'(cdb_src[1:0]), 64'd3);
            end
            cyc();
        end
        chk("wrap_idle", 64'(cdb_valid), 64'(0));
        chk("wrap_count", 64'(rd_i[3]), 64'd10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
